// File: rtl/pipe_stage_buffer_pkg.sv
// Shared definitions for elastic pipeline stages: NOP encoding, IF/ID payload
// packing and the stall counter width. Every stage instance imports this so
// that all of them agree on the layout.
package pipe_stage_buffer_pkg;

   localparam logic [31:0] NOP_INSTR   = 32'b0;
   localparam int          STALL_CNT_W = 32;

   // IF/ID payload as concatenated by the instantiator, MSB first
   typedef struct packed {
      logic [31:0] instr;
      logic [31:0] pc_plus4;
      logic [31:0] pc;
      logic        bra_delay;
      logic        flushed;
   } if_id_t;

   localparam int IF_ID_WIDTH      = $bits(if_id_t);
   localparam int IF_ID_FLUSHED_LSB = 0;
   localparam int IF_ID_BRA_LSB     = 1;
   localparam int IF_ID_PC_LSB      = 2;
   localparam int IF_ID_PC4_LSB     = 34;
   localparam int IF_ID_INSTR_LSB   = 66;

endpackage

// File: rtl/pipe_stage_buffer_if.sv
// Valid/ready beat channel. The producer uses the master modport and the
// consumer uses the slave modport.
interface pipe_stage_buffer_if #(parameter int WIDTH = 32);
   logic             valid;
   logic             ready;
   logic [WIDTH-1:0] data;

   modport master (output valid, output data, input  ready);
   modport slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/pipe_stage_mem.sv
// DEPTH x WIDTH register array with one write port and one async read port.
// The storage has no reset; the owning buffer masks empty slots to zero.
module pipe_stage_mem #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2,
   parameter int AW    = 1
) (
   input  logic             clock,
   input  logic             we,
   input  logic [AW-1:0]    waddr,
   input  logic [WIDTH-1:0] wdata,
   input  logic [AW-1:0]    raddr,
   output logic [WIDTH-1:0] rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   // write the accepted beat into the tail slot
   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic pipeline stage: DEPTH-entry in-order buffer with valid/ready on both
// sides. Flush empties the buffer and drops the incoming beat. Empty slots
// present all-zero data (NOP bubble).
// Optional feature: define PIPE_STAGE_STALL_CNT_EN to enable the saturating
// backpressure counter on stall_cycles; otherwise it reads as zero.
module pipe_stage_buffer
   import pipe_stage_buffer_pkg::*;
#(
   parameter int WIDTH = 32,
   parameter int DEPTH = 2
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         flush,
   pipe_stage_buffer_if.slave           up,
   pipe_stage_buffer_if.master          dn,
   output logic                         dn_flushed,
   output logic [$clog2(DEPTH+1)-1:0]   occupancy,
   output logic [STALL_CNT_W-1:0]       stall_cycles
);

   localparam int             AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int             CW   = $clog2(DEPTH+1);
   localparam logic [AW-1:0]  LAST = AW'(DEPTH-1);
   localparam logic [CW-1:0]  FULL = CW'(DEPTH);

   logic [AW-1:0]    head, tail;
   logic [CW-1:0]    occ;
   logic             can_take, has_beat, push, pop;
   logic [WIDTH-1:0] head_data;

   // explicit wrap so non-power-of-2 DEPTH works
   function automatic logic [AW-1:0] wrap_inc(input logic [AW-1:0] p);
      return (p == LAST) ? '0 : p + 1'b1;
   endfunction

   // ready comes from registered occupancy only, never from dn.ready
   assign can_take  = (occ < FULL);
   assign has_beat  = (occ != '0);
   assign push      = up.valid & can_take & ~flush;
   assign pop       = has_beat & dn.ready & ~flush;

   assign up.ready  = can_take;
   assign dn.valid  = has_beat;
   assign dn.data   = has_beat ? head_data : '0;
   assign occupancy = occ;

   pipe_stage_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
      .clock (clock),
      .we    (push),
      .waddr (tail),
      .wdata (up.data),
      .raddr (head),
      .rdata (head_data)
   );

   // pointers and occupancy; flush overrides any push/pop
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else if (flush) begin
         head <= '0;
         tail <= '0;
         occ  <= '0;
      end else begin
         if (push) tail <= wrap_inc(tail);
         if (pop)  head <= wrap_inc(head);
         case ({push, pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

   // one pulse per flush cycle; consecutive flushes keep it high
   always_ff @(posedge clock or posedge reset) begin
      if (reset) dn_flushed <= 1'b0;
      else       dn_flushed <= flush;
   end

`ifdef PIPE_STAGE_STALL_CNT_EN
   logic [STALL_CNT_W-1:0] stall_q;

   // count cycles where a head beat is held back by the consumer, saturating
   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         stall_q <= '0;
      else if (has_beat && !dn.ready && !flush && (stall_q != '1))
         stall_q <= stall_q + 1'b1;
   end

   assign stall_cycles = stall_q;
`else
   assign stall_cycles = '0;
`endif

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: a DEPTH=2 and a DEPTH=3 instance
// sharing clock and reset, one task per scenario.
module tb_pipe_stage_buffer;

   logic clock = 1'b0;
   logic reset = 1'b1;
   logic flush2 = 1'b0, flush3 = 1'b0;

   logic        fl2, fl3;
   logic [1:0]  occ2;
   logic [2:0]  occ3;
   logic [31:0] st2, st3;

   int n_checks = 0;
   int n_fail   = 0;

`ifdef PIPE_STAGE_STALL_CNT_EN
   localparam logic [31:0] EXP_STALL = 32'd5;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
`endif

   pipe_stage_buffer_if #(.WIDTH(32)) u2 ();
   pipe_stage_buffer_if #(.WIDTH(32)) n2 ();
   pipe_stage_buffer_if #(.WIDTH(32)) u3 ();
   pipe_stage_buffer_if #(.WIDTH(32)) n3 ();

   pipe_stage_buffer #(.WIDTH(32), .DEPTH(2)) dut2 (
      .clock(clock), .reset(reset), .flush(flush2), .up(u2.slave), .dn(n2.master),
      .dn_flushed(fl2), .occupancy(occ2), .stall_cycles(st2));

   pipe_stage_buffer #(.WIDTH(32), .DEPTH(3)) dut3 (
      .clock(clock), .reset(reset), .flush(flush3), .up(u3.slave), .dn(n3.master),
      .dn_flushed(fl3), .occupancy(occ3), .stall_cycles(st3));

   always #5 clock = ~clock;

   // advance to just after the next rising edge
   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic test_reset();
      #2;
      n_checks++;
      if (occ2 !== 2'd0 || n2.valid !== 1'b0 || n2.data !== 32'd0 || fl2 !== 1'b0 || st2 !== 32'd0) begin
         n_fail++;
         $display("FAIL reset_state: occ=%0d valid=%b data=%h flushed=%b stall=%0d, required all zero",
                  occ2, n2.valid, n2.data, fl2, st2);
      end
      n_checks++;
      if (u2.ready !== 1'b1 || occ3 !== 3'd0) begin
         n_fail++;
         $display("FAIL reset_ready: up_ready=%b occ3=%0d, required 1 and 0", u2.ready, occ3);
      end
   endtask

   task automatic test_stream();
      for (int k = 0; k < 8; k++) begin
         cyc();
         u2.valid = 1'b1; u2.data = 32'(k + 1); n2.ready = 1'b1;
         #2;
         n_checks++;
         if (u2.ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stream_up_ready k=%0d: got %b, required 1", k, u2.ready);
         end
         n_checks++;
         if (k == 0) begin
            if (n2.valid !== 1'b0) begin
               n_fail++;
               $display("FAIL stream_no_bypass: dn_valid=%b, required 0", n2.valid);
            end
         end else if (n2.valid !== 1'b1 || n2.data !== 32'(k)) begin
            n_fail++;
            $display("FAIL stream_data k=%0d: valid=%b data=%h, required 1 %h", k, n2.valid, n2.data, 32'(k));
         end
      end
      cyc();
      u2.valid = 1'b0;
      #2;
      n_checks++;
      if (n2.valid !== 1'b1 || n2.data !== 32'd8) begin
         n_fail++;
         $display("FAIL stream_last: valid=%b data=%h, required 1 00000008", n2.valid, n2.data);
      end
      cyc();
      #2;
      n_checks++;
      if (n2.valid !== 1'b0 || n2.data !== 32'd0 || occ2 !== 2'd0) begin
         n_fail++;
         $display("FAIL stream_drain: valid=%b data=%h occ=%0d, required 0 0 0", n2.valid, n2.data, occ2);
      end
   endtask

   task automatic test_backpressure();
      n2.ready = 1'b0;
      for (int k = 0; k < 3; k++) begin
         cyc();
         u2.valid = 1'b1; u2.data = 32'hA1 + 32'(k);
      end
      #2;
      n_checks++;
      if (u2.ready !== 1'b0 || occ2 !== 2'd2 || n2.data !== 32'hA1) begin
         n_fail++;
         $display("FAIL bp_full: up_ready=%b occ=%0d data=%h, required 0 2 000000a1", u2.ready, occ2, n2.data);
      end
      cyc();
      u2.valid = 1'b0; n2.ready = 1'b1;
      #2;
      n_checks++;
      if (n2.valid !== 1'b1 || n2.data !== 32'hA1 || u2.ready !== 1'b0) begin
         n_fail++;
         $display("FAIL bp_pop1: valid=%b data=%h up_ready=%b, required 1 000000a1 0", n2.valid, n2.data, u2.ready);
      end
      cyc();
      #2;
      n_checks++;
      if (n2.valid !== 1'b1 || n2.data !== 32'hA2 || u2.ready !== 1'b1 || occ2 !== 2'd1) begin
         n_fail++;
         $display("FAIL bp_pop2: valid=%b data=%h up_ready=%b occ=%0d, required 1 000000a2 1 1",
                  n2.valid, n2.data, u2.ready, occ2);
      end
      cyc();
      #2;
      n_checks++;
      if (n2.valid !== 1'b0 || occ2 !== 2'd0) begin
         n_fail++;
         $display("FAIL bp_dropped_beat: valid=%b data=%h occ=%0d, required empty", n2.valid, n2.data, occ2);
      end
   endtask

   task automatic test_flush();
      n2.ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cyc();
         u2.valid = 1'b1; u2.data = 32'hB1 + 32'(k);
      end
      cyc();
      flush2 = 1'b1; u2.valid = 1'b1; u2.data = 32'hB3;
      #2;
      n_checks++;
      if (occ2 !== 2'd2 || fl2 !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_pre: occ=%0d flushed=%b, required 2 0", occ2, fl2);
      end
      cyc();
      flush2 = 1'b0; u2.valid = 1'b0;
      #2;
      n_checks++;
      if (occ2 !== 2'd0 || n2.valid !== 1'b0 || n2.data !== 32'd0 || fl2 !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_effect: occ=%0d valid=%b data=%h flushed=%b, required 0 0 0 1",
                  occ2, n2.valid, n2.data, fl2);
      end
      cyc();
      flush2 = 1'b1;
      #2;
      n_checks++;
      if (fl2 !== 1'b0 || n2.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_pulse_width: flushed=%b valid=%b, required 0 0", fl2, n2.valid);
      end
      // two consecutive flushes on an empty buffer
      cyc();
      #2;
      n_checks++;
      if (fl2 !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_b2b_first: flushed=%b, required 1", fl2);
      end
      cyc();
      flush2 = 1'b0;
      #2;
      n_checks++;
      if (fl2 !== 1'b1) begin
         n_fail++;
         $display("FAIL flush_b2b_held: flushed=%b, required 1", fl2);
      end
      cyc();
      #2;
      n_checks++;
      if (fl2 !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_b2b_end: flushed=%b, required 0", fl2);
      end
   endtask

   task automatic test_wrap_depth3();
      logic [63:0] pat;
      int sent, rcvd, max_occ;
      pat = 64'hA5C3_96F0_0F3C_9870;
      sent = 0; rcvd = 0; max_occ = 0;
      for (int t = 0; t < 64 && rcvd < 10; t++) begin
         cyc();
         u3.valid = (sent < 10);
         u3.data  = 32'hC0 + 32'(sent);
         n3.ready = pat[t];
         #2;
         if (int'(occ3) > max_occ) max_occ = int'(occ3);
         n_checks++;
         if (occ3 > 3'd3) begin
            n_fail++;
            $display("FAIL wrap_occ t=%0d: occ=%0d, required <=3", t, occ3);
         end
         if (n3.valid && n3.ready) begin
            n_checks++;
            if (n3.data !== 32'hC0 + 32'(rcvd)) begin
               n_fail++;
               $display("FAIL wrap_order beat=%0d: got %h, required %h", rcvd, n3.data, 32'hC0 + 32'(rcvd));
            end
            rcvd++;
         end
         if (u3.valid && u3.ready) sent++;
      end
      u3.valid = 1'b0; n3.ready = 1'b0;
      n_checks++;
      if (rcvd != 10 || max_occ != 3) begin
         n_fail++;
         $display("FAIL wrap_complete: received=%0d max_occ=%0d, required 10 and 3", rcvd, max_occ);
      end
   endtask

   task automatic test_async_reset();
      n2.ready = 1'b0;
      for (int k = 0; k < 2; k++) begin
         cyc();
         u2.valid = 1'b1; u2.data = 32'hD1 + 32'(k);
      end
      cyc();
      u2.valid = 1'b0;
      #2;
      n_checks++;
      if (occ2 !== 2'd2 || n2.data !== 32'hD1) begin
         n_fail++;
         $display("FAIL areset_pre: occ=%0d data=%h, required 2 000000d1", occ2, n2.data);
      end
      reset = 1'b1;
      #1;
      n_checks++;
      if (occ2 !== 2'd0 || n2.valid !== 1'b0 || n2.data !== 32'd0 || st2 !== 32'd0) begin
         n_fail++;
         $display("FAIL areset_async: occ=%0d valid=%b data=%h stall=%0d, required all zero",
                  occ2, n2.valid, n2.data, st2);
      end
      cyc();
      reset = 1'b0; n2.ready = 1'b1;
      cyc();
      #2;
      n_checks++;
      if (n2.valid !== 1'b0 || n2.data !== 32'd0 || occ2 !== 2'd0) begin
         n_fail++;
         $display("FAIL areset_stale: valid=%b data=%h occ=%0d, required 0 0 0", n2.valid, n2.data, occ2);
      end
   endtask

   task automatic test_stall_count();
      cyc();
      n2.ready = 1'b0; u2.valid = 1'b1; u2.data = 32'hE1;
      cyc();
      u2.valid = 1'b0;
      for (int k = 0; k < 5; k++) cyc();
      #2;
      n_checks++;
      if (st2 !== EXP_STALL || n2.data !== 32'hE1) begin
         n_fail++;
         $display("FAIL stall_count: stall=%0d data=%h, required %0d 000000e1", st2, n2.data, EXP_STALL);
      end
      n2.ready = 1'b1;
      cyc();
      #2;
      n_checks++;
      if (st2 !== EXP_STALL || n2.valid !== 1'b0) begin
         n_fail++;
         $display("FAIL stall_hold: stall=%0d valid=%b, required %0d 0", st2, n2.valid, EXP_STALL);
      end
   endtask

   initial begin
      u2.valid = 1'b0; u2.data = '0; n2.ready = 1'b0;
      u3.valid = 1'b0; u3.data = '0; n3.ready = 1'b0;
      cyc();
      cyc();
      reset = 1'b0;
      test_reset();
      test_stream();
      test_backpressure();
      test_flush();
      test_wrap_depth3();
      test_async_reset();
      test_stall_count();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
